// File: rtl/gtfraw_vnc_reset_sequencer.sv
// Multi-channel reset synchroniser and staggered release sequencer.
// Async assert, sync deassert; channels leave reset in index order after a hold time.
module gtfraw_vnc_reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic              sw_reset_req,
  input  logic [NUM_CH-1:0] ch_hold,
  output logic [NUM_CH-1:0] reset,
  output logic              reset_done
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] FIRST_STAGGERED = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rst_sync_n;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   released_q, released_d;
  logic [NUM_CH-1:0]   reset_q, reset_d;
  logic                reset_done_q, reset_done_d;

  // Deassertion synchroniser: shifts in ones once reset_async is released.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencer: the counter only advances once the synchronised reset is released,
  // and a software request overrides any release scheduled for the same edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    released_d   = released_q;
    reset_done_d = reset_done_q;

    if (sw_reset_req) begin
      state_d      = ST_ASSERT;
      cnt_d        = '0;
      idx_d        = '0;
      released_d   = '0;
      reset_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (rst_sync_n) begin
            if (cnt_q == HOLD_LAST) begin
              cnt_d         = '0;
              released_d[0] = 1'b1;
              if (NUM_CH == 1) begin
                state_d      = ST_DONE;
                reset_done_d = 1'b1;
              end else begin
                state_d = ST_RELEASE;
                idx_d   = FIRST_STAGGERED;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (idx_q == IDX_W'(i)) begin
                released_d[i] = 1'b1;
              end
            end
            if (idx_q == LAST_IDX) begin
              state_d      = ST_DONE;
              reset_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  // Hold gates act only on the registered outputs, never on the sequencing.
  always_comb begin
    reset_d = released_d & ~ch_hold;
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      idx_q        <= '0;
      released_q   <= '0;
      reset_q      <= '0;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      released_q   <= released_d;
      reset_q      <= reset_d;
      reset_done_q <= reset_done_d;
    end
  end

  assign reset      = reset_q;
  assign reset_done = reset_done_q;

endmodule

// File: tb/tb_gtfraw_vnc_reset_sequencer.sv
// Scoreboard bench: a schedule-based reference model queues expected outputs per edge,
// a monitor process pops and compares them at their due time.
module tb_gtfraw_vnc_reset_sequencer;

  localparam int N  = 4;
  localparam int SS = 3;
  localparam int HC = 16;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         reset_async;
  logic         sw_reset_req;
  logic [N-1:0] ch_hold;
  logic [N-1:0] reset;
  logic         reset_done;

  logic         rb_n;
  logic         sw2;
  logic [0:0]   hold2;
  logic [0:0]   reset2;
  logic         done2;

  always #5 clk = ~clk;

  gtfraw_vnc_reset_sequencer #(
    .NUM_CH(N), .SYNC_STAGES(SS), .HOLD_CYCLES(HC), .STAGGER_CYCLES(SC)
  ) dut (
    .clk(clk), .reset_async(reset_async), .sw_reset_req(sw_reset_req),
    .ch_hold(ch_hold), .reset(reset), .reset_done(reset_done)
  );

  gtfraw_vnc_reset_sequencer #(
    .NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(8)
  ) dut1 (
    .clk(clk), .reset_async(rb_n), .sw_reset_req(sw2),
    .ch_hold(hold2), .reset(reset2), .reset_done(done2)
  );

  typedef struct {
    longint       t;
    logic [N-1:0] r;
    logic         d;
    string        tag;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: edge count, synchroniser progress, entry edge.
  int edge_n   = 0;
  int sync_cnt = 0;
  bit e_valid  = 1'b0;
  int e_edge   = 0;

  task automatic cmp(input string tag, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: {done,reset} got %b expected %b", tag, $time, act, exp);
    end
  endtask

  task automatic push(input longint t, input string tag, input logic [N-1:0] r, input logic d);
    exp_t e;
    e.t = t; e.r = r; e.d = d; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic model_async_clear();
    sync_cnt = 0;
    e_valid  = 1'b0;
  endtask

  // Inputs for the next edge are applied at a negedge; the expectation for
  // that edge is derived from the release schedule E + HOLD + i*STAGGER.
  task automatic step(input logic sw, input logic [N-1:0] hold);
    logic [N-1:0] rel;
    sw_reset_req = sw;
    ch_hold      = hold;
    edge_n++;
    if (!reset_async) begin
      model_async_clear();
    end else if (sync_cnt < SS) begin
      sync_cnt++;
      if (sync_cnt == SS) begin
        e_valid = 1'b1;
        e_edge  = edge_n;
      end
    end else if (sw) begin
      e_edge = edge_n;
    end
    rel = '0;
    for (int i = 0; i < N; i++) begin
      rel[i] = e_valid && (edge_n >= e_edge + HC + i * SC);
    end
    push(10 * edge_n - 4, $sformatf("edge%0d", edge_n), rel & ~hold, rel[N-1]);
    @(negedge clk);
  endtask

  task automatic async_drop();
    reset_async = 1'b0;
    model_async_clear();
    push($time + 1, "async_assert", '0, 1'b0);
  endtask

  task automatic async_pulse();
    #2;
    async_drop();
    #2;
    reset_async = 1'b1;
  endtask

  // Monitor: compares each expectation when it falls due.
  initial begin
    exp_t e;
    forever begin
      #1;
      while (q.size() != 0 && q[0].t <= $time) begin
        e = q.pop_front();
        cmp(e.tag, {reset_done, reset}, {e.d, e.r});
      end
      while (q2.size() != 0 && q2[0].t <= $time) begin
        e = q2.pop_front();
        cmp(e.tag, (N+1)'({done2, reset2}), (N+1)'({e.d, e.d}));
      end
    end
  end

  // Single-channel instance: E is edge 2, release one edge later.
  initial begin
    exp_t e;
    rb_n  = 1'b1;
    sw2   = 1'b0;
    hold2 = 1'b0;
    #1 rb_n = 1'b0;
    e.t = 2; e.r = '0; e.d = 1'b0; e.tag = "n1_por";
    q2.push_back(e);
    for (int n = 1; n <= 13; n++) begin
      e.t   = 10 * n - 4;
      e.d   = (n >= 3) && (n != 10);
      e.r   = '0;
      e.tag = $sformatf("n1_edge%0d", n);
      q2.push_back(e);
    end
    #2 rb_n = 1'b1;
    #87 sw2 = 1'b1;
    #10 sw2 = 1'b0;
  end

  initial begin
    logic [N-1:0] h;
    logic         sw;
    reset_async  = 1'b1;
    sw_reset_req = 1'b0;
    ch_hold      = '0;
    #1;
    async_drop();
    #2 reset_async = 1'b1;

    repeat (30) step(1'b0, '0);
    async_drop();
    repeat (19) step(1'b0, '0);
    reset_async = 1'b1;
    repeat (50) step(1'b0, '0);
    step(1'b1, '0);
    repeat (49) step(1'b0, '0);
    repeat (5) step(1'b1, '0);
    repeat (45) step(1'b0, '0);
    repeat (11) step(1'b0, 4'b0100);
    repeat (9) step(1'b0, '0);
    async_pulse();
    repeat (40) step(1'b0, 4'b0010);
    repeat (20) step(1'b0, '0);

    h = '0;
    for (int k = 0; k < 700; k++) begin
      sw = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) h[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) async_pulse();
      if ($urandom_range(0, 199) == 0) begin
        async_drop();
        repeat ($urandom_range(1, 5)) step(1'b0, h);
        reset_async = 1'b1;
      end
      step(sw, h);
    end
    repeat (60) step(1'b0, '0);

    for (int k = 0; k < 100 && (q.size() != 0 || q2.size() != 0); k++) #1;
    if (q.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
